cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between result producers: ALU behind the RS, load/store buffer, and branch unit.
- Each source has a one-entry holding buffer.
- A round-robin arbiter picks one buffered result per cycle and drives it onto a registered CDB.
- Consumers are the ROB and the RS/LSB dependency-wakeup logic.
- Sits between the execution units and the ROB; flushes on rob_clear.

Parameters:
- NUM_SRC, 3, number of result sources. Index 0 = ALU, 1 = LSB, 2 = branch unit.
- ROB_SIZE_BIT, 4, width of a ROB id.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous active-high reset.
- rdy_in  input  1  global ready; all state frozen when low.
- rob_clear  input  1  pipeline flush (misprediction); effective only when rdy_in=1.
- src_valid  input  NUM_SRC  per-source result valid.
- src_value  input  NUM_SRC*32  source i value in bits [i*32 +: 32].
- src_rob_id  input  NUM_SRC*ROB_SIZE_BIT  source i ROB id in bits [i*ROB_SIZE_BIT +: ROB_SIZE_BIT].
- src_ready  output  NUM_SRC  per-source accept. A transfer occurs when src_valid[i] && src_ready[i] at a rising clk_in.
- cdb_valid  output  1  CDB broadcast valid, registered.
- cdb_value  output  32  broadcast value, registered.
- cdb_rob_id  output  ROB_SIZE_BIT  broadcast ROB id, registered.
- cdb_src  output  2  index of the winning source, registered. Width is clog2(NUM_SRC), minimum 1.

Behaviour:
- State per source i: hold_valid[i], hold_value[i], hold_rob_id[i].
- Global state: rr_ptr (0..NUM_SRC-1) plus the CDB output registers.
- Reset: asynchronous.
  - All hold_valid=0, rr_ptr=0.
  - cdb_valid=0, cdb_value=0, cdb_rob_id=0, cdb_src=0.
  - A reset mid-operation discards every buffered result.
- Arbitration is combinational: win[i] is true for the first i with hold_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_SRC. At most one win is set.
- src_ready[i] = rdy_in && !rob_clear && (!hold_valid[i] || win[i]).
  - A winning buffer can be refilled in the same cycle it drains.
- Each rising edge with rdy_in=1 and rob_clear=0:
  - If a winner k exists: cdb_valid<=1, cdb_value<=hold_value[k], cdb_rob_id<=hold_rob_id[k], cdb_src<=k, hold_valid[k]<=0, rr_ptr<=(k+1) mod NUM_SRC.
  - If no winner: cdb_valid<=0; rr_ptr and cdb data unchanged.
  - Any accepted source writes its hold buffer and sets hold_valid. This write overrides the drain of the same entry.
- Latency:
  - Minimum 2 edges from the accepting edge to cdb_valid visible.
  - Source accepted at edge E0 → hold_valid after E0 → on CDB after E1 if it wins.
  - cdb_valid is a one-cycle pulse per broadcast.
- Backpressure: while a buffer is full and losing, src_ready[i]=0. The source must hold valid/value/rob_id stable.
- Fairness: a continuously pending source is granted within NUM_SRC cycles.
- rob_clear (with rdy_in=1), at the edge:
  - all hold_valid<=0, cdb_valid<=0, rr_ptr<=0.
  - src_ready is 0 during the flush cycle, so no inputs are accepted.
- rdy_in=0:
  - Every register keeps its value, cdb_valid included; consumers freeze on rdy_in too.
  - src_ready=0; rob_clear is ignored.
- Simultaneous rst_in and anything else: reset wins.

Optional Feature:
- Macro: CDB_FIXED_PRIO_EN.
- Defined:
  - rr_ptr is removed.
  - The winner is the lowest-index source with hold_valid=1, so the ALU always beats LSB, which always beats the branch unit.
  - The fairness guarantee is dropped.
- Undefined: round-robin behaviour as above.
- Ports, latency and flush behaviour are identical in both builds.

Test Plan:
- Reset mid-operation: buffer sources 0 and 2, pulse rst_in asynchronously between edges.
  - Outputs go 0 immediately; with rdy_in=1, src_ready=3'b111.
  - No cdb_valid afterward.
- Single source: src 1 drives 0xDEADBEEF, rob 5, for one cycle with ready=1.
  - Exactly one cdb_valid pulse, 2 edges later: value 0xDEADBEEF, rob_id 5, cdb_src 1.
- Three-way collision, rr_ptr=0: all sources valid at the same edge (values 0x11/0x22/0x33, robs 1/2/3).
  - CDB shows src 0, 1, 2 on three consecutive cycles; rr_ptr returns to 0.
  - A source presenting a new value during its drain cycle has src_ready=1.
- Fairness: src0 and src2 held continuously valid.
  - Grants alternate 0,2,0,2.
  - With CDB_FIXED_PRIO_EN, grants are 0,0,0 and src_ready[2] stays 0 once its buffer is full.
- Flush: two buffers full plus a new src_valid; assert rob_clear with rdy_in=1.
  - src_ready=0 that cycle.
  - The next cycle has cdb_valid=0, and no stale rob_id is ever broadcast.
- Stall: pending entries, rdy_in=0 for 3 cycles.
  - cdb outputs and buffers unchanged, src_ready=0.
  - After rdy_in returns to 1, the broadcast order continues exactly as without the stall.

Source files
------------

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Shares the single common data bus (CDB) between the result producers
//   (index 0 = ALU behind the RS, 1 = load/store buffer, 2 = branch unit).
//   Each producer owns a one-entry holding buffer.  A combinational arbiter
//   picks one buffered result per cycle and the pick is broadcast on a
//   registered CDB to the ROB and the RS/LSB wakeup logic.  The whole block
//   freezes while rdy_in is low and drops every buffered result on rob_clear.
//
// Build option:
//   CDB_FIXED_PRIO_EN  when defined, the round-robin pointer is removed and
//                      the lowest-index buffered source always wins
//                      (ALU > LSB > branch).  When undefined (default) the
//                      arbiter is round-robin and starvation-free.
//
// Ports:
//   clk_in      system clock
//   rst_in      asynchronous active-high reset
//   rdy_in      global ready; all state frozen while low
//   rob_clear   pipeline flush, effective only while rdy_in is high
//   src_valid   per-source result valid
//   src_value   source i value in bits [i*32 +: 32]
//   src_rob_id  source i ROB id in bits [i*ROB_SIZE_BIT +: ROB_SIZE_BIT]
//   src_ready   per-source accept (transfer on valid && ready at clk_in rise)
//   cdb_valid   registered broadcast valid (one-cycle pulse per broadcast)
//   cdb_value   registered broadcast value
//   cdb_rob_id  registered broadcast ROB id
//   cdb_src     registered index of the winning source
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int NUM_SRC      = 3,
  parameter int ROB_SIZE_BIT = 4,
  localparam int SRC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              rdy_in,
  input  logic                              rob_clear,
  input  logic [NUM_SRC-1:0]                src_valid,
  input  logic [NUM_SRC*32-1:0]             src_value,
  input  logic [NUM_SRC*ROB_SIZE_BIT-1:0]   src_rob_id,
  output logic [NUM_SRC-1:0]                src_ready,
  output logic                              cdb_valid,
  output logic [31:0]                       cdb_value,
  output logic [ROB_SIZE_BIT-1:0]           cdb_rob_id,
  output logic [SRC_W-1:0]                  cdb_src
);

  logic [NUM_SRC-1:0]      holdValid_q, holdValid_d;
  logic [31:0]             holdValue_q [NUM_SRC];
  logic [31:0]             holdValue_d [NUM_SRC];
  logic [ROB_SIZE_BIT-1:0] holdRob_q   [NUM_SRC];
  logic [ROB_SIZE_BIT-1:0] holdRob_d   [NUM_SRC];

  logic                    cdbValid_q, cdbValid_d;
  logic [31:0]             cdbValue_q, cdbValue_d;
  logic [ROB_SIZE_BIT-1:0] cdbRob_q,   cdbRob_d;
  logic [SRC_W-1:0]        cdbSrc_q,   cdbSrc_d;

  logic                    winFound;
  logic [SRC_W-1:0]        winIdx;
  logic [SRC_W:0]          scanSum;

`ifndef CDB_FIXED_PRIO_EN
  logic [SRC_W-1:0]        rrPtr_q, rrPtr_d;
`endif

  // Winner selection: walk the buffers starting at the round-robin pointer
  // (or at index 0 in the fixed-priority build) and take the first full one.
  // The scan index is one bit wider so the wrap can be done by a single
  // conditional subtract instead of a modulo.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    scanSum  = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
`ifdef CDB_FIXED_PRIO_EN
      scanSum = (SRC_W+1)'(off);
`else
      scanSum = {1'b0, rrPtr_q} + (SRC_W+1)'(off);
      if (scanSum >= (SRC_W+1)'(NUM_SRC)) begin
        scanSum = scanSum - (SRC_W+1)'(NUM_SRC);
      end
`endif
      if (!winFound && holdValid_q[scanSum[SRC_W-1:0]]) begin
        winFound = 1'b1;
        winIdx   = scanSum[SRC_W-1:0];
      end
    end
  end

  // A source may hand over a result when its buffer is empty, or when the
  // buffer is draining onto the CDB this very cycle (refill-on-drain).
  always_comb begin
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = rdy_in && !rob_clear &&
                     (!holdValid_q[i] || (winFound && (winIdx == SRC_W'(i))));
    end
  end

  // Next-state logic.  Nothing moves while rdy_in is low.  A flush empties
  // every buffer and silences the CDB but leaves the last broadcast data in
  // place.  Otherwise the winner drains onto the CDB and any accepted source
  // writes its buffer afterwards, so a refill overrides the drain.
  always_comb begin
    holdValid_d = holdValid_q;
    holdValue_d = holdValue_q;
    holdRob_d   = holdRob_q;
    cdbValid_d  = cdbValid_q;
    cdbValue_d  = cdbValue_q;
    cdbRob_d    = cdbRob_q;
    cdbSrc_d    = cdbSrc_q;
`ifndef CDB_FIXED_PRIO_EN
    rrPtr_d     = rrPtr_q;
`endif
    if (rdy_in && rob_clear) begin
      holdValid_d = '0;
      cdbValid_d  = 1'b0;
`ifndef CDB_FIXED_PRIO_EN
      rrPtr_d     = '0;
`endif
    end else if (rdy_in) begin
      if (winFound) begin
        cdbValid_d          = 1'b1;
        cdbValue_d          = holdValue_q[winIdx];
        cdbRob_d            = holdRob_q[winIdx];
        cdbSrc_d            = winIdx;
        holdValid_d[winIdx] = 1'b0;
`ifndef CDB_FIXED_PRIO_EN
        rrPtr_d = (winIdx == SRC_W'(NUM_SRC-1)) ? '0 : winIdx + 1'b1;
`endif
      end else begin
        cdbValid_d = 1'b0;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          holdValid_d[i] = 1'b1;
          holdValue_d[i] = src_value[i*32 +: 32];
          holdRob_d[i]   = src_rob_id[i*ROB_SIZE_BIT +: ROB_SIZE_BIT];
        end
      end
    end
  end

  // State registers.  Reset discards every buffered result and zeroes the
  // CDB; the buffer payloads are cleared too so nothing stale is ever visible.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      holdValid_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        holdValue_q[i] <= '0;
        holdRob_q[i]   <= '0;
      end
      cdbValid_q <= 1'b0;
      cdbValue_q <= '0;
      cdbRob_q   <= '0;
      cdbSrc_q   <= '0;
`ifndef CDB_FIXED_PRIO_EN
      rrPtr_q    <= '0;
`endif
    end else begin
      holdValid_q <= holdValid_d;
      holdValue_q <= holdValue_d;
      holdRob_q   <= holdRob_d;
      cdbValid_q  <= cdbValid_d;
      cdbValue_q  <= cdbValue_d;
      cdbRob_q    <= cdbRob_d;
      cdbSrc_q    <= cdbSrc_d;
`ifndef CDB_FIXED_PRIO_EN
      rrPtr_q     <= rrPtr_d;
`endif
    end
  end

  assign cdb_valid  = cdbValid_q;
  assign cdb_value  = cdbValue_q;
  assign cdb_rob_id = cdbRob_q;
  assign cdb_src    = cdbSrc_q;

endmodule
